// File: rtl/multicycle_control_unit.sv
// Multi-cycle main control: Moore FSM sequencing fetch/decode/execute/memory/write-back
// over a shared memory port and ALU, with retired-instruction counting and sticky illegal-opcode flag.
module multicycle_control_unit #(
    parameter int unsigned              OPCODE_W      = 6,
    parameter int unsigned              ALUOP_W       = 2,
    parameter int unsigned              CNT_W         = 16,
    parameter bit                       MEM_HANDSHAKE = 1'b1,
    parameter logic [OPCODE_W-1:0]      OP_R          = 6'h00,
    parameter logic [OPCODE_W-1:0]      OP_ADDI       = 6'h08,
    parameter logic [OPCODE_W-1:0]      OP_SUBI       = 6'h09,
    parameter logic [OPCODE_W-1:0]      OP_LWI        = 6'h0A,
    parameter logic [OPCODE_W-1:0]      OP_BEQ        = 6'h04,
    parameter logic [OPCODE_W-1:0]      OP_J          = 6'h02,
    parameter logic [OPCODE_W-1:0]      OP_LW         = 6'h23,
    parameter logic [OPCODE_W-1:0]      OP_SW         = 6'h2B
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [3:0]          state,
    output logic                instr_done,
    output logic                illegal_op,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_IMMEXEC = 4'd8,
        S_IMMWB   = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

    state_t                state_q, state_d;
    logic [OPCODE_W-1:0]   op_q;
    logic                  illegal_q;
    logic [CNT_W-1:0]      retired_q;
    logic                  rdy;
    logic                  done_c;
    logic                  illegal_set;

    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
            if (done_c) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = ALU_ADD;
        done_c      = 1'b0;
        illegal_set = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = rdy;
                PCWrite = rdy;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                // Branch on the live opcode here; op_q only holds it from the next cycle on.
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADDR;
                end else if (opcode == OP_R) begin
                    state_d = S_EXEC;
                end else if (opcode == OP_ADDI || opcode == OP_SUBI || opcode == OP_LWI) begin
                    state_d = S_IMMEXEC;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    state_d     = S_FETCH;
                    illegal_set = 1'b1;
                end
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                done_c   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (rdy) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                done_c   = 1'b1;
                state_d  = S_FETCH;
            end
            S_IMMEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (op_q == OP_SUBI) ? ALU_SUB : ALU_ADD;
                state_d = S_IMMWB;
            end
            S_IMMWB: begin
                RegWrite = 1'b1;
                done_c   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                done_c   = 1'b1;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset dominates every decode, including a wait in the middle of an access.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            PCSource    = 2'b00;
            ALUOp       = ALU_ADD;
            done_c      = 1'b0;
            illegal_set = 1'b0;
        end
    end

    assign state      = state_q;
    assign instr_done = done_c;
    assign illegal_op = illegal_q & ~rst;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle vector table plus hand sequences
// for illegal-op stickiness, reset mid-access, counter wrap and the no-handshake variant.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b1;

    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic       RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic [3:0] state;
    logic       instr_done, illegal_op;
    logic [15:0] retired;

    logic       rst2 = 1'b1;
    logic [5:0] opcode2 = 6'h02;
    logic       b_PCWrite, b_PCWriteCond, b_IorD, b_MemRead, b_MemWrite, b_MemtoReg, b_IRWrite;
    logic       b_RegDst, b_RegWrite, b_ALUSrcA;
    logic [1:0] b_ALUSrcB, b_PCSource, b_ALUOp;
    logic [3:0] b_state;
    logic       b_instr_done, b_illegal_op;
    logic [3:0] b_retired;

    logic [15:0] ctl;
    assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp};

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .state(state), .instr_done(instr_done), .illegal_op(illegal_op),
        .retired(retired)
    );

    multicycle_control_unit #(.CNT_W(4), .MEM_HANDSHAKE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst2), .opcode(opcode2), .mem_ready(1'b0),
        .PCWrite(b_PCWrite), .PCWriteCond(b_PCWriteCond), .IorD(b_IorD), .MemRead(b_MemRead),
        .MemWrite(b_MemWrite), .MemtoReg(b_MemtoReg), .IRWrite(b_IRWrite), .RegDst(b_RegDst),
        .RegWrite(b_RegWrite), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB), .PCSource(b_PCSource),
        .ALUOp(b_ALUOp), .state(b_state), .instr_done(b_instr_done), .illegal_op(b_illegal_op),
        .retired(b_retired)
    );

    // Bundle order: PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite RegDst RegWrite ALUSrcA ALUSrcB PCSource ALUOp
    localparam logic [15:0] C_ZERO  = 16'h0000;
    localparam logic [15:0] C_FRDY  = 16'h9210;
    localparam logic [15:0] C_FWAIT = 16'h1010;
    localparam logic [15:0] C_DEC   = 16'h0030;
    localparam logic [15:0] C_MADDR = 16'h0060;
    localparam logic [15:0] C_MRD   = 16'h3000;
    localparam logic [15:0] C_MWB   = 16'h0480;
    localparam logic [15:0] C_MWR   = 16'h2800;
    localparam logic [15:0] C_EXEC  = 16'h0042;
    localparam logic [15:0] C_RWB   = 16'h0180;
    localparam logic [15:0] C_IADD  = 16'h0060;
    localparam logic [15:0] C_ISUB  = 16'h0061;
    localparam logic [15:0] C_IWB   = 16'h0080;
    localparam logic [15:0] C_BR    = 16'h4045;
    localparam logic [15:0] C_JMP   = 16'h8008;

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        done;
        logic        ill;
        logic [15:0] ret;
    } vec_t;

    vec_t vt[37];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic rdy);
        @(negedge clk);
        rst       = r;
        opcode    = op;
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        vt[0]  = '{1'b1, 6'h00, 1'b1, 4'd0,  C_ZERO,  1'b0, 1'b0, 16'd0};
        vt[1]  = '{1'b0, 6'h00, 1'b1, 4'd0,  C_FRDY,  1'b0, 1'b0, 16'd0};
        vt[2]  = '{1'b0, 6'h00, 1'b1, 4'd1,  C_DEC,   1'b0, 1'b0, 16'd0};
        vt[3]  = '{1'b0, 6'h3F, 1'b1, 4'd6,  C_EXEC,  1'b0, 1'b0, 16'd0};
        vt[4]  = '{1'b0, 6'h00, 1'b1, 4'd7,  C_RWB,   1'b1, 1'b0, 16'd0};
        vt[5]  = '{1'b0, 6'h23, 1'b1, 4'd0,  C_FRDY,  1'b0, 1'b0, 16'd1};
        vt[6]  = '{1'b0, 6'h23, 1'b1, 4'd1,  C_DEC,   1'b0, 1'b0, 16'd1};
        vt[7]  = '{1'b0, 6'h00, 1'b1, 4'd2,  C_MADDR, 1'b0, 1'b0, 16'd1};
        vt[8]  = '{1'b0, 6'h00, 1'b0, 4'd3,  C_MRD,   1'b0, 1'b0, 16'd1};
        vt[9]  = '{1'b0, 6'h00, 1'b0, 4'd3,  C_MRD,   1'b0, 1'b0, 16'd1};
        vt[10] = '{1'b0, 6'h00, 1'b1, 4'd3,  C_MRD,   1'b0, 1'b0, 16'd1};
        vt[11] = '{1'b0, 6'h00, 1'b1, 4'd4,  C_MWB,   1'b1, 1'b0, 16'd1};
        vt[12] = '{1'b0, 6'h09, 1'b0, 4'd0,  C_FWAIT, 1'b0, 1'b0, 16'd2};
        vt[13] = '{1'b0, 6'h09, 1'b1, 4'd0,  C_FRDY,  1'b0, 1'b0, 16'd2};
        vt[14] = '{1'b0, 6'h09, 1'b1, 4'd1,  C_DEC,   1'b0, 1'b0, 16'd2};
        vt[15] = '{1'b0, 6'h00, 1'b0, 4'd8,  C_ISUB,  1'b0, 1'b0, 16'd2};
        vt[16] = '{1'b0, 6'h00, 1'b1, 4'd9,  C_IWB,   1'b1, 1'b0, 16'd2};
        vt[17] = '{1'b0, 6'h04, 1'b1, 4'd0,  C_FRDY,  1'b0, 1'b0, 16'd3};
        vt[18] = '{1'b0, 6'h04, 1'b1, 4'd1,  C_DEC,   1'b0, 1'b0, 16'd3};
        vt[19] = '{1'b0, 6'h04, 1'b1, 4'd10, C_BR,    1'b1, 1'b0, 16'd3};
        vt[20] = '{1'b0, 6'h02, 1'b1, 4'd0,  C_FRDY,  1'b0, 1'b0, 16'd4};
        vt[21] = '{1'b0, 6'h02, 1'b1, 4'd1,  C_DEC,   1'b0, 1'b0, 16'd4};
        vt[22] = '{1'b0, 6'h02, 1'b1, 4'd11, C_JMP,   1'b1, 1'b0, 16'd4};
        vt[23] = '{1'b0, 6'h2B, 1'b1, 4'd0,  C_FRDY,  1'b0, 1'b0, 16'd5};
        vt[24] = '{1'b0, 6'h2B, 1'b1, 4'd1,  C_DEC,   1'b0, 1'b0, 16'd5};
        vt[25] = '{1'b0, 6'h00, 1'b1, 4'd2,  C_MADDR, 1'b0, 1'b0, 16'd5};
        vt[26] = '{1'b0, 6'h00, 1'b0, 4'd5,  C_MWR,   1'b0, 1'b0, 16'd5};
        vt[27] = '{1'b0, 6'h00, 1'b1, 4'd5,  C_MWR,   1'b1, 1'b0, 16'd5};
        vt[28] = '{1'b0, 6'h08, 1'b1, 4'd0,  C_FRDY,  1'b0, 1'b0, 16'd6};
        vt[29] = '{1'b0, 6'h08, 1'b1, 4'd1,  C_DEC,   1'b0, 1'b0, 16'd6};
        vt[30] = '{1'b0, 6'h08, 1'b1, 4'd8,  C_IADD,  1'b0, 1'b0, 16'd6};
        vt[31] = '{1'b0, 6'h08, 1'b1, 4'd9,  C_IWB,   1'b1, 1'b0, 16'd6};
        vt[32] = '{1'b0, 6'h3F, 1'b1, 4'd0,  C_FRDY,  1'b0, 1'b0, 16'd7};
        vt[33] = '{1'b0, 6'h3F, 1'b1, 4'd1,  C_DEC,   1'b0, 1'b0, 16'd7};
        vt[34] = '{1'b0, 6'h02, 1'b1, 4'd0,  C_FRDY,  1'b0, 1'b1, 16'd7};
        vt[35] = '{1'b0, 6'h02, 1'b1, 4'd1,  C_DEC,   1'b0, 1'b1, 16'd7};
        vt[36] = '{1'b0, 6'h02, 1'b1, 4'd11, C_JMP,   1'b1, 1'b1, 16'd7};

        repeat (2) @(posedge clk);

        for (int i = 0; i < 37; i++) begin
            drive(vt[i].r, vt[i].op, vt[i].rdy);
            chk($sformatf("v%0d.state", i), 32'(state), 32'(vt[i].st));
            chk($sformatf("v%0d.ctl", i), 32'(ctl), 32'(vt[i].ctl));
            chk($sformatf("v%0d.done", i), 32'(instr_done), 32'(vt[i].done));
            chk($sformatf("v%0d.illegal", i), 32'(illegal_op), 32'(vt[i].ill));
            chk($sformatf("v%0d.retired", i), 32'(retired), 32'(vt[i].ret));
        end

        // illegal_op stays set across 10 more jump instructions
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 3; c++) begin
                drive(1'b0, 6'h02, 1'b1);
                chk("sticky.illegal", 32'(illegal_op), 32'd1);
            end
        end
        drive(1'b0, 6'h2B, 1'b1);
        chk("sticky.retired", 32'(retired), 32'd18);
        chk("sticky.state", 32'(state), 32'd0);

        // SW, then reset asserted while MEMWR waits on memory
        drive(1'b0, 6'h2B, 1'b1);
        chk("rstwr.decode", 32'(state), 32'd1);
        drive(1'b0, 6'h00, 1'b1);
        chk("rstwr.memaddr", 32'(state), 32'd2);
        drive(1'b0, 6'h00, 1'b0);
        chk("rstwr.memwr_state", 32'(state), 32'd5);
        chk("rstwr.memwr_ctl", 32'(ctl), 32'(C_MWR));
        drive(1'b1, 6'h00, 1'b0);
        chk("rstwr.memwrite_in_rst", 32'(MemWrite), 32'd0);
        chk("rstwr.ctl_in_rst", 32'(ctl), 32'(C_ZERO));
        chk("rstwr.done_in_rst", 32'(instr_done), 32'd0);
        chk("rstwr.illegal_in_rst", 32'(illegal_op), 32'd0);
        drive(1'b0, 6'h00, 1'b1);
        chk("rstwr.state_after", 32'(state), 32'd0);
        chk("rstwr.retired_after", 32'(retired), 32'd0);
        chk("rstwr.illegal_after", 32'(illegal_op), 32'd0);
        chk("rstwr.ctl_after", 32'(ctl), 32'(C_FRDY));

        // CNT_W=4, no handshake, mem_ready tied low: 16 jumps wrap the counter
        @(negedge clk);
        rst2 = 1'b0;
        opcode2 = 6'h02;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("wrap.fetch_state", 32'(b_state), 32'd0);
            chk("wrap.fetch_irwrite", 32'(b_IRWrite), 32'd1);
            chk("wrap.retired", 32'(b_retired), 32'(k));
            @(negedge clk);
            #1;
            chk("wrap.decode_state", 32'(b_state), 32'd1);
            @(negedge clk);
            #1;
            chk("wrap.jump_done", 32'(b_instr_done), 32'd1);
            @(negedge clk);
        end
        #1;
        chk("wrap.retired_zero", 32'(b_retired), 32'd0);
        chk("wrap.state_fetch", 32'(b_state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multi-cycle successor to the single-cycle main decoder: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back steps. It shares one memory port and one ALU, and waits on a memory-ready handshake. It sits between the instruction register (opcode source) and the datapath muxes/enables, the register file, the memory and the ALU control. It keeps the existing instruction set: R-type, ADDI, SUBI, LWI, BEQ, J, LW, SW.

## Interface
Parameters:
- OPCODE_W, 6, opcode width
- ALUOP_W, 2, ALUOp width to ALU control (codes 0=add, 1=sub, 2=funct; upper bits zero)
- CNT_W, 16, retired-instruction counter width
- MEM_HANDSHAKE, 1, 1 = wait for mem_ready; 0 = memory assumed ready every cycle (mem_ready ignored)
- OP_R, OP_ADDI, OP_SUBI, OP_LWI, OP_BEQ, OP_J, OP_LW, OP_SW; defaults 6'h00, 6'h08, 6'h09, 6'h0A, 6'h04, 6'h02, 6'h23, 6'h2B; opcode values

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  OPCODE_W  from instruction register
- mem_ready  in  1  memory access completes this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls
- ALUSrcB  out  2  00=reg B, 01=const 1, 10=sign-ext imm, 11=imm (branch offset)
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ALUOp  out  ALUOP_W
- state  out  4  current state encoding (debug)
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  out  1  sticky, set on an undefined opcode
- retired  out  CNT_W  count of completed instructions

## Operation
- Outputs are decoded from the state register only (Moore), except IRWrite/PCWrite in FETCH, which are qualified by rdy (rdy = mem_ready, or 1 if MEM_HANDSHAKE=0).
- Any output not listed for a state is 0.
- The opcode is latched into op_q in DECODE. All later branching uses op_q, so opcode may change after DECODE.
- States, with encoding, asserted outputs and next state:
  - FETCH(0): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0, PCSource=00, IRWrite=rdy, PCWrite=rdy. Next is DECODE if rdy, else hold.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=0. Next by opcode:
    - LW/SW → MEMADDR(2)
    - R → EXEC(6)
    - ADDI/SUBI/LWI → IMMEXEC(8)
    - BEQ → BRANCH(10)
    - J → JUMP(11)
    - other → FETCH, set illegal_op, no instr_done
  - MEMADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=0. Next is MEMRD(3) if op_q=LW, else MEMWR(5).
  - MEMRD(3): MemRead, IorD=1. Next is MEMWB(4) if rdy, else hold.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite. Next is FETCH.
  - MEMWR(5): MemWrite, IorD=1. Next is FETCH if rdy, else hold.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=2. Next is RWB(7).
  - RWB(7): RegDst=1, RegWrite. Next is FETCH.
  - IMMEXEC(8): ALUSrcA=1, ALUSrcB=10. ALUOp=1 for SUBI, 0 for ADDI/LWI. Next is IMMWB(9).
  - IMMWB(9): RegDst=0, MemtoReg=0, RegWrite. Next is FETCH.
  - BRANCH(10): ALUSrcA=1, ALUSrcB=00, ALUOp=1, PCWriteCond, PCSource=01. Next is FETCH.
  - JUMP(11): PCWrite, PCSource=10. Next is FETCH.
- Encodings 12–15 are unreachable. If entered, go to FETCH with all outputs 0.
- instr_done is high in MEMWB, MEMWR (when rdy), RWB, IMMWB, BRANCH and JUMP. On each instr_done, retired increments, wrapping 2^CNT_W−1 → 0.
- illegal_op clears only on rst.

## Timing
- Reset (rst high at an edge): state=FETCH, op_q=0, retired=0, illegal_op=0.
- While rst is high, all control outputs, instr_done and illegal_op read 0. This overrides the FETCH decode and holds even mid-instruction; the in-flight instruction is abandoned with no write.
- Latency with rdy=1 throughout:
  - J, BEQ: 3 cycles
  - R, ADDI, SUBI, LWI, SW: 4 cycles
  - LW: 5 cycles
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle. Outputs are held stable while waiting; IRWrite/PCWrite stay low until rdy.
- mem_ready is ignored in all other states.

## Test plan
- Reset then R-type (opcode 0x00), mem_ready=1 → states 0,1,6,7,0. RWB has RegDst=1 and RegWrite=1. instr_done pulses once; retired=1.
- LW (0x23) with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4. MemRead and IorD=1 are held through the wait. MEMWB has MemtoReg=1.
- SUBI (0x09) → IMMEXEC has ALUOp=1 and ALUSrcB=10. BEQ (0x04) → PCWriteCond=1 and PCSource=01 for exactly 1 cycle. J → PCWrite=1 and PCSource=10.
- Opcode 0x3F → DECODE goes to FETCH and illegal_op=1 (sticky over 10 further instructions). retired is unchanged; only rst clears illegal_op.
- rst asserted in MEMWR while mem_ready=0 → next cycle state=0. MemWrite is never high while rst is high; retired=0.
- CNT_W=4, 16 back-to-back J instructions → retired wraps 15→0. MEM_HANDSHAKE=0 with mem_ready tied 0 → FETCH still advances in 1 cycle.
